// File: rtl/ext_int_pkg.sv
// Shared definitions for the external-interrupt conditioner: edge-select encodings,
// miss-counter width and the debounce counter width helper.
package ext_int_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   localparam int unsigned MISS_CNT_W = 8;

   // clog2 of the debounce length, never narrower than one bit
   function automatic int unsigned deb_cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/ext_int_channel.sv
// One interrupt channel: synchronizer, debounce filter, edge qualifier and sticky pending flag.
// With INT_COND_MISS_CNT_EN defined, a saturating missed-event counter is built as well.
module ext_int_channel
   import ext_int_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RESET_LEVEL     = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pin_in,
   input  logic [1:0]            edge_sel,
   input  logic                  irq_ack,
   output logic                  irq_pulse,
   output logic                  irq_pending,
   output logic                  filt_level,
   output logic [MISS_CNT_W-1:0] miss_cnt
);

   localparam int unsigned     CntW   = deb_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic            RstLvl = (RESET_LEVEL != 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   pulse_q, pulse_d;
   logic                   pend_q, pend_d;
   logic                   s, rise_en, fall_en;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pin_in};
      s       = sync_q[SYNC_STAGES-1];
      rise_en = (edge_sel == EDGE_RISE) || (edge_sel == EDGE_BOTH);
      fall_en = (edge_sel == EDGE_FALL) || (edge_sel == EDGE_BOTH);
      cnt_d   = '0;
      filt_d  = filt_q;
      pulse_d = 1'b0;
      // cnt holds how many prior cycles s already disagreed with the filtered level
      if (s != filt_q) begin
         if (cnt_q == CntMax) begin
            filt_d  = s;
            pulse_d = s ? rise_en : fall_en;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // a pulse in the same cycle as an ack wins
      pend_d = (pend_q & ~irq_ack) | pulse_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= {SYNC_STAGES{RstLvl}};
         cnt_q   <= '0;
         filt_q  <= RstLvl;
         pulse_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
      end
   end

   assign irq_pulse   = pulse_q;
   assign irq_pending = pend_q;
   assign filt_level  = filt_q;

`ifdef INT_COND_MISS_CNT_EN
   logic [MISS_CNT_W-1:0] miss_q, miss_d;

   always_comb begin
      miss_d = miss_q;
      if (pulse_q && pend_q && !irq_ack && (miss_q != '1)) begin
         miss_d = miss_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         miss_q <= '0;
      end else begin
         miss_q <= miss_d;
      end
   end

   assign miss_cnt = miss_q;
`else
   assign miss_cnt = '0;
`endif

endmodule

// File: rtl/ext_int_conditioner.sv
// Conditions raw external-interrupt pins into clean interrupt pulses and pending flags.
// Optional missed-event counters are built when INT_COND_MISS_CNT_EN is defined.
module ext_int_conditioner
   import ext_int_pkg::*;
#(
   parameter int unsigned NUM_CH          = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RESET_LEVEL     = 0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            pin_in,
   input  logic [2*NUM_CH-1:0]          edge_sel,
   input  logic [NUM_CH-1:0]            irq_ack,
   output logic [NUM_CH-1:0]            irq_pulse,
   output logic [NUM_CH-1:0]            irq_pending,
   output logic [NUM_CH-1:0]            filt_level,
   output logic [MISS_CNT_W*NUM_CH-1:0] miss_cnt
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ext_int_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_LEVEL)
      ) u_ch (
         .clock       (clock),
         .reset       (reset),
         .pin_in      (pin_in[i]),
         .edge_sel    (edge_sel[2*i +: 2]),
         .irq_ack     (irq_ack[i]),
         .irq_pulse   (irq_pulse[i]),
         .irq_pending (irq_pending[i]),
         .filt_level  (filt_level[i]),
         .miss_cnt    (miss_cnt[MISS_CNT_W*i +: MISS_CNT_W])
      );
   end

endmodule

// File: tb/tb_ext_int_conditioner.sv
// Self-checking bench for ext_int_conditioner: directed scenarios plus random pin activity,
// all compared every cycle against a cycle-level behavioural model.
module tb_ext_int_conditioner;

   localparam int NUM_CH = 2;
   localparam int SS     = 2;
   localparam int DC     = 16;
`ifdef INT_COND_MISS_CNT_EN
   localparam bit MISS_ON = 1'b1;
`else
   localparam bit MISS_ON = 1'b0;
`endif

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NUM_CH-1:0]     pin_in;
   logic [2*NUM_CH-1:0]   edge_sel;
   logic [NUM_CH-1:0]     irq_ack;
   logic [NUM_CH-1:0]     irq_pulse, irq_pending, filt_level;
   logic [8*NUM_CH-1:0]   miss_cnt;

   int tests = 0;
   int fails = 0;

   ext_int_conditioner #(
      .NUM_CH          (NUM_CH),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .RESET_LEVEL     (0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pin_in      (pin_in),
      .edge_sel    (edge_sel),
      .irq_ack     (irq_ack),
      .irq_pulse   (irq_pulse),
      .irq_pending (irq_pending),
      .filt_level  (filt_level),
      .miss_cnt    (miss_cnt)
   );

   always #5 clock = ~clock;

   // Behavioural model: synchronizer as a shift history, debounce as a run length of
   // consecutive disagreeing samples, pending/miss as plain event bookkeeping.
   bit m_sync [NUM_CH][SS];
   int m_run  [NUM_CH];
   bit m_filt [NUM_CH];
   bit m_pulse[NUM_CH];
   bit m_pend [NUM_CH];
   int m_miss [NUM_CH];

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < SS; k++) m_sync[c][k] = 1'b0;
         m_run[c] = 0; m_filt[c] = 1'b0; m_pulse[c] = 1'b0; m_pend[c] = 1'b0; m_miss[c] = 0;
      end
   endfunction

   function automatic void model_clock();
      bit s, flip, want;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         s    = m_sync[c][SS-1];
         flip = 1'b0;
         if (s != m_filt[c]) begin
            m_run[c]++;
            if (m_run[c] >= DC) begin
               flip = 1'b1;
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
         if (MISS_ON && m_pulse[c] && m_pend[c] && !irq_ack[c] && m_miss[c] < 255) m_miss[c]++;
         m_pend[c] = (m_pend[c] && !irq_ack[c]) || m_pulse[c];
         want = s ? edge_sel[2*c] : edge_sel[2*c+1];
         m_pulse[c] = flip && want;
         if (flip) m_filt[c] = s;
         for (int k = SS-1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
         m_sync[c][0] = pin_in[c];
      end
   endfunction

   task automatic check_all(input string tag);
      logic [NUM_CH-1:0]   ef, ep, eq;
      logic [8*NUM_CH-1:0] em;
      for (int c = 0; c < NUM_CH; c++) begin
         ef[c] = m_filt[c]; ep[c] = m_pulse[c]; eq[c] = m_pend[c];
         em[8*c +: 8] = 8'(m_miss[c]);
      end
      tests += 4;
      assert (filt_level === ef) else begin
         fails++; $error("FAIL %s filt_level got %b exp %b", tag, filt_level, ef);
      end
      assert (irq_pulse === ep) else begin
         fails++; $error("FAIL %s irq_pulse got %b exp %b", tag, irq_pulse, ep);
      end
      assert (irq_pending === eq) else begin
         fails++; $error("FAIL %s irq_pending got %b exp %b", tag, irq_pending, eq);
      end
      assert (miss_cnt === em) else begin
         fails++; $error("FAIL %s miss_cnt got %h exp %h", tag, miss_cnt, em);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_clock();
      #1;
      check_all(tag);
   endtask

   task automatic steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   // steps until irq_pulse[ch] is seen; n = steps taken, or -1 if the bound expires
   task automatic wait_pulse(input int ch, input int limit, input string tag, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step(tag);
         if (irq_pulse[ch] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int ch, input int n, input string tag, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         step(tag);
         if (irq_pulse[ch] === 1'b1) cnt++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all("reset_assert");
      steps(3, "in_reset");
      reset = 1'b1;
   endtask

   int lat, pc, pc2, bound;
   int exp_miss;

   initial begin
      reset = 1'b1; pin_in = '0; edge_sel = '0; irq_ack = '0;
      model_reset();
      #2;
      // 1: reset and idle
      do_reset();
      steps(100, "idle");
      tests++;
      assert ({irq_pulse, irq_pending, filt_level, miss_cnt} === '0) else begin
         fails++; $error("FAIL idle_all_zero got %h exp 0", {irq_pulse, irq_pending, filt_level});
      end

      // 2: rising edge latency, pending and ack
      edge_sel = 4'b0001;
      pin_in[0] = 1'b1;
      wait_pulse(0, 100, "rise_lat", lat);
      tests++;
      assert (lat === SS + DC) else begin
         fails++; $error("FAIL rise_latency got %0d exp %0d", lat, SS + DC);
      end
      step("pulse_one_cycle");
      tests++;
      assert (irq_pulse[0] === 1'b0 && irq_pending[0] === 1'b1) else begin
         fails++; $error("FAIL pulse_width got p=%b q=%b exp p=0 q=1", irq_pulse[0], irq_pending[0]);
      end
      steps(5, "pend_hold");
      irq_ack[0] = 1'b1;
      step("ack");
      irq_ack[0] = 1'b0;
      tests++;
      assert (irq_pending[0] === 1'b0) else begin
         fails++; $error("FAIL ack_clears got %b exp 0", irq_pending[0]);
      end

      // 3: 15-cycle glitches on ch1 are filtered, 16 cycles are not
      edge_sel = 4'b0100;
      pc = 0;
      for (int r = 0; r < 5; r++) begin
         pin_in[1] = 1'b1;
         count_pulses(1, 15, "glitch_hi", pc2); pc += pc2;
         pin_in[1] = 1'b0;
         count_pulses(1, 15, "glitch_lo", pc2); pc += pc2;
      end
      tests++;
      assert (pc === 0 && filt_level[1] === 1'b0) else begin
         fails++; $error("FAIL glitch_filtered got pulses=%0d filt=%b exp 0/0", pc, filt_level[1]);
      end
      pin_in[1] = 1'b1;
      count_pulses(1, 16, "hi16", pc);
      pin_in[1] = 1'b0;
      count_pulses(1, 40, "hi16_tail", pc2);
      tests++;
      assert (pc + pc2 === 1) else begin
         fails++; $error("FAIL sixteen_cycle_pulse got %0d exp 1", pc + pc2);
      end

      // 4: edge modes on ch0 (pin0 currently high, filtered high)
      for (int m = 0; m < 4; m++) begin
         logic [1:0] mode;
         int exp_r, exp_f;
         mode = (m == 0) ? 2'b10 : (m == 1) ? 2'b11 : (m == 2) ? 2'b00 : 2'b01;
         exp_r = (mode == 2'b01 || mode == 2'b11) ? 1 : 0;
         exp_f = (mode == 2'b10 || mode == 2'b11) ? 1 : 0;
         edge_sel = {2'b00, mode};
         pin_in[0] = 1'b0;
         count_pulses(0, 30, "mode_fall", pc);
         pin_in[0] = 1'b1;
         count_pulses(0, 30, "mode_rise", pc2);
         tests++;
         assert (pc === exp_f && pc2 === exp_r && filt_level[0] === 1'b1) else begin
            fails++; $error("FAIL edge_mode_%b got f=%0d r=%0d exp f=%0d r=%0d", mode, pc, pc2,
                            exp_f, exp_r);
         end
      end

      // 5: ack coincident with pulse, then miss counting
      do_reset();
      edge_sel = 4'b0011;
      irq_ack[0] = 1'b1;
      pin_in[0] = 1'b0;
      steps(5, "pre_ack");
      pin_in[0] = 1'b1;
      wait_pulse(0, 60, "ack_same", lat);
      step("ack_same_after");
      tests++;
      assert (lat > 0 && irq_pending[0] === 1'b1) else begin
         fails++; $error("FAIL set_wins_over_ack got lat=%0d q=%b exp q=1", lat, irq_pending[0]);
      end
      step("ack_clear");
      irq_ack[0] = 1'b0;
      for (int t = 0; t < 3; t++) begin
         pin_in[0] = ~pin_in[0];
         steps(20, "miss3");
      end
      exp_miss = MISS_ON ? 2 : 0;
      tests++;
      assert (miss_cnt[7:0] === 8'(exp_miss)) else begin
         fails++; $error("FAIL miss_three got %0d exp %0d", miss_cnt[7:0], exp_miss);
      end
      for (int t = 0; t < 300; t++) begin
         pin_in[0] = ~pin_in[0];
         steps(19, "miss300");
      end
      exp_miss = MISS_ON ? 255 : 0;
      tests++;
      assert (miss_cnt[7:0] === 8'(exp_miss)) else begin
         fails++; $error("FAIL miss_saturate got %0d exp %0d", miss_cnt[7:0], exp_miss);
      end

      // 6: reset mid-debounce with pending set
      do_reset();
      edge_sel = 4'b0001;
      pin_in[0] = 1'b1;
      wait_pulse(0, 60, "pre6", lat);
      step("pre6_pend");
      pin_in[0] = 1'b0;
      bound = 0;
      while (m_run[0] != 10 && bound < 60) begin
         step("to_cnt10");
         bound++;
      end
      tests++;
      assert (bound < 60 && irq_pending[0] === 1'b1) else begin
         fails++; $error("FAIL reach_cnt10 got bound=%0d q=%b exp q=1", bound, irq_pending[0]);
      end
      reset = 1'b0;
      #1;
      model_reset();
      tests++;
      assert ({irq_pulse, irq_pending, filt_level, miss_cnt} === '0) else begin
         fails++; $error("FAIL reset_immediate got %h exp 0", {irq_pulse, irq_pending, filt_level});
      end
      steps(2, "in_reset6");
      reset = 1'b1;
      count_pulses(0, 40, "post_release", pc);
      tests++;
      assert (pc === 0) else begin
         fails++; $error("FAIL no_spurious got %0d exp 0", pc);
      end

      // random activity on both channels
      do_reset();
      for (int r = 0; r < 120; r++) begin
         pin_in   = NUM_CH'($urandom);
         edge_sel = 4'($urandom);
         for (int k = 0; k < int'($urandom_range(25, 1)); k++) begin
            irq_ack = ($urandom_range(3, 0) == 0) ? NUM_CH'($urandom) : '0;
            step("random");
         end
      end
      irq_ack = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
